puzzle_state_engine: RTL and testbench

Parametrised successor to the 3x3 puzzle memory. Holds an NxN sliding-puzzle board and a route log in one host-addressable map. Adds a hardware move engine: blank-tile moves with legality checking, automatic route logging, a solved flag and overflow status. Sits between the search controller (issues moves) and the display/debug logic (reads board and route).

---
 rtl/puzzle_pkg.sv | 40 ++++
 rtl/puzzle_state_engine_if.sv | 21 ++
 rtl/puzzle_route_log.sv | 67 ++++++
 rtl/puzzle_state_engine.sv | 163 ++++++++++++++++
 tb/tb_puzzle_state_engine.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/puzzle_pkg.sv
// Shared types and helpers for the sliding-puzzle state engine.
// Move directions describe where the blank travels; route entries store dir+1.
package puzzle_pkg;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_e;
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, APPLY = 2'd2} state_e;

  localparam int ROUTE_EMPTY = 0;

  typedef struct packed {
    logic        legal;
    logic [15:0] idx;
  } nbr_t;

  typedef struct packed {
    logic undo;
    dir_e dir;
  } req_t;

  function automatic dir_e inv_dir(dir_e d);
    return dir_e'(d ^ 2'd1);
  endfunction

  function automatic nbr_t nbr_idx(int unsigned pos, dir_e dir, int unsigned n);
    int unsigned row, col;
    nbr_t r;
    row     = pos / n;
    col     = pos % n;
    r.legal = 1'b1;
    r.idx   = 16'(pos);
    case (dir)
      UP:      if (row == 0)     r.legal = 1'b0; else r.idx = 16'(pos - n);
      DOWN:    if (row == n - 1) r.legal = 1'b0; else r.idx = 16'(pos + n);
      LEFT:    if (col == 0)     r.legal = 1'b0; else r.idx = 16'(pos - 1);
      default: if (col == n - 1) r.legal = 1'b0; else r.idx = 16'(pos + 1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/puzzle_state_engine_if.sv
// Host map bus plus move/undo handshake of the puzzle state engine.
interface puzzle_state_engine_if #(
  parameter int AW = 8,
  parameter int W  = 8
);
  logic [AW-1:0] host_addr;
  logic          host_we;
  logic [W-1:0]  host_din;
  logic [W-1:0]  host_dout;
  logic          move_valid;
  logic [1:0]    move_dir;
  logic          move_ready;
  logic          undo_valid;
  logic          move_done;
  logic          move_err;

  modport master (output host_addr, host_we, host_din, move_valid, move_dir, undo_valid,
                  input  host_dout, move_ready, move_done, move_err);
  modport slave  (input  host_addr, host_we, host_din, move_valid, move_dir, undo_valid,
                  output host_dout, move_ready, move_done, move_err);
endinterface

// File: rtl/puzzle_route_log.sv
// Route log: stack of applied directions (dir+1), count and sticky overflow.
module puzzle_route_log
  import puzzle_pkg::*;
#(
  parameter int R = 32,
  parameter int W = 8,
  localparam int CW  = $clog2(R + 1),
  localparam int RIW = (R > 1) ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           push_i,
  input  logic [W-1:0]   push_val_i,
  input  logic           pop_i,
  input  logic [RIW-1:0] rd_idx_i,
  output logic [W-1:0]   rd_data_o,
  output logic [W-1:0]   top_o,
  output logic [CW-1:0]  cnt_o,
  output logic           ovf_o
);
  logic [R-1:0][W-1:0] ent_q, ent_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [RIW-1:0]      wr_ptr, top_ptr;

  assign wr_ptr  = cnt_q[RIW-1:0];
  assign top_ptr = wr_ptr - RIW'(1);

  // clear beats a same-cycle append or pop
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      ent_d = {R{W'(ROUTE_EMPTY)}};
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (push_i) begin
      if (cnt_q == CW'(R)) ovf_d = 1'b1;
      else begin
        ent_d[wr_ptr] = push_val_i;
        cnt_d         = cnt_q + CW'(1);
      end
    end else if (pop_i && cnt_q != '0) begin
      ent_d[top_ptr] = W'(ROUTE_EMPTY);
      cnt_d          = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= {R{W'(ROUTE_EMPTY)}};
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign rd_data_o = ent_q[rd_idx_i];
  assign top_o     = ent_q[top_ptr];
  assign cnt_o     = cnt_q;
  assign ovf_o     = ovf_q;
endmodule

// File: rtl/puzzle_state_engine.sv
// NxN sliding-puzzle board with move engine, route log and solved flag.
// Optional PUZZLE_UNDO_EN: undo rewinds the last logged move; otherwise undo always errors.
module puzzle_state_engine
  import puzzle_pkg::*;
#(
  parameter int N          = 3,
  parameter int W          = 8,
  parameter int R          = 32,
  parameter int AW         = 8,
  parameter int ROUTE_BASE = 16,
  parameter logic [N*N*W-1:0] INIT_BOARD = 72'h00_08_07_01_05_03_04_06_02,
  parameter int INIT_BLANK = 8,
  localparam int NC  = N * N,
  localparam int IW  = $clog2(NC),
  localparam int CW  = $clog2(R + 1),
  localparam int RIW = (R > 1) ? $clog2(R) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  puzzle_state_engine_if.slave  bus,
  input  logic                  route_clr,
  output logic [IW-1:0]         blank_pos,
  output logic [CW-1:0]         route_cnt,
  output logic                  route_ovf,
  output logic                  solved
);
  if (NC > ROUTE_BASE || ROUTE_BASE + R > 2 ** AW) begin : g_bad_map
    $error("puzzle_state_engine: board and route regions do not fit the address map");
  end

  state_e               state_q, state_d;
  req_t                 req_q, req_d;
  logic [IW-1:0]        nbr_q, nbr_d, blank_q, blank_d;
  logic                 legal_q, legal_d, done_q, done_d, err_q, err_d, solved_q;
  logic [NC-1:0][W-1:0] board_q, board_d, goal;
  logic                 push, pop, ovf;
  logic [W-1:0]         top, rd_data;
  logic [CW-1:0]        cnt;
  logic                 is_cell, is_route, unused_bits;
  logic [IW-1:0]        cell_a;
  logic [RIW-1:0]       route_a;
  dir_e                 eff_dir;
  nbr_t                 nb;

  assign is_cell  = bus.host_addr < AW'(NC);
  assign is_route = ({1'b0, bus.host_addr} >= (AW+1)'(ROUTE_BASE)) &&
                    ({1'b0, bus.host_addr} <  (AW+1)'(ROUTE_BASE + R));
  assign cell_a   = bus.host_addr[IW-1:0];
  assign route_a  = RIW'(bus.host_addr - AW'(ROUTE_BASE));
  assign bus.host_dout = is_cell ? board_q[cell_a] : (is_route ? rd_data : '0);

  // an undo travels opposite to the direction stored on top of the log
  always_comb begin
    eff_dir = req_q.dir;
`ifdef PUZZLE_UNDO_EN
    if (req_q.undo) eff_dir = inv_dir(dir_e'(top[1:0] - 2'd1));
`endif
  end

  assign nb          = nbr_idx(32'(blank_q), eff_dir, N);
  assign unused_bits = ^{nb.idx, top};

  always_comb begin
    for (int k = 0; k < NC; k++) goal[k] = (k == NC - 1) ? '0 : W'(k + 1);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    nbr_d   = nbr_q;
    legal_d = legal_q;
    board_d = board_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.host_we && is_cell) begin
          board_d[cell_a] = bus.host_din;
          if (bus.host_din == '0) blank_d = cell_a;
        end
        if (bus.undo_valid || bus.move_valid) begin
          req_d.undo = bus.undo_valid;
          req_d.dir  = dir_e'(bus.move_dir);
          state_d    = CHECK;
        end
      end
      CHECK: begin
        nbr_d   = IW'(nb.idx);
        legal_d = nb.legal;
        if (req_q.undo) begin
`ifdef PUZZLE_UNDO_EN
          legal_d = nb.legal && (cnt != '0);
`else
          legal_d = 1'b0;
`endif
        end
        state_d = APPLY;
      end
      APPLY: begin
        if (legal_q) begin
          board_d[blank_q] = board_q[nbr_q];
          board_d[nbr_q]   = '0;
          blank_d          = nbr_q;
          push             = !req_q.undo;
          pop              = req_q.undo;
        end
        done_d  = 1'b1;
        err_d   = !legal_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      nbr_q    <= '0;
      legal_q  <= 1'b0;
      board_q  <= INIT_BOARD;
      blank_q  <= IW'(INIT_BLANK);
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      solved_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      nbr_q    <= nbr_d;
      legal_q  <= legal_d;
      board_q  <= board_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
      err_q    <= err_d;
      solved_q <= (board_q == goal);
    end
  end

  puzzle_route_log #(.R(R), .W(W)) u_log (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (route_clr),
    .push_i    (push),
    .push_val_i(W'(req_q.dir) + W'(1)),
    .pop_i     (pop),
    .rd_idx_i  (route_a),
    .rd_data_o (rd_data),
    .top_o     (top),
    .cnt_o     (cnt),
    .ovf_o     (ovf)
  );

  assign bus.move_ready = (state_q == IDLE);
  assign bus.move_done  = done_q;
  assign bus.move_err   = err_q;
  assign blank_pos      = blank_q;
  assign route_cnt      = cnt;
  assign route_ovf      = ovf;
  assign solved         = solved_q;
endmodule

// File: tb/tb_puzzle_state_engine.sv
// Bench for puzzle_state_engine (R=4) against a board/route-stack reference model.
module tb_puzzle_state_engine;
  localparam int N = 3, W = 8, R = 4, AW = 8, RB = 16, NC = 9;

  logic       clk = 1'b0, rst = 1'b1, route_clr = 1'b0;
  logic [3:0] blank_pos;
  logic [2:0] route_cnt;
  logic       route_ovf, solved;

  puzzle_state_engine_if #(.AW(AW), .W(W)) bus();

  puzzle_state_engine #(.N(N), .W(W), .R(R), .AW(AW), .ROUTE_BASE(RB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .route_clr(route_clr),
    .blank_pos(blank_pos), .route_cnt(route_cnt), .route_ovf(route_ovf), .solved(solved)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int init_b[NC] = '{2, 6, 4, 3, 5, 1, 7, 8, 0};
  int m_board[NC];
  int m_blank;
  int m_route[$];
  bit m_ovf;

  function automatic void model_reset();
    m_board = init_b; m_blank = 8; m_route.delete(); m_ovf = 0;
  endfunction

  function automatic bit model_try(int dir);
    int r = m_blank / N, c = m_blank % N, nb = 0;
    bit ok = 0;
    case (dir)
      0:       begin ok = (r > 0);     nb = m_blank - N; end
      1:       begin ok = (r < N - 1); nb = m_blank + N; end
      2:       begin ok = (c > 0);     nb = m_blank - 1; end
      default: begin ok = (c < N - 1); nb = m_blank + 1; end
    endcase
    if (ok) begin m_board[m_blank] = m_board[nb]; m_board[nb] = 0; m_blank = nb; end
    return ok;
  endfunction

  // returns the expected error flag
  function automatic bit model_req(bit undo, int dir);
    if (!undo) begin
      if (!model_try(dir)) return 1;
      if (m_route.size() < R) m_route.push_back(dir + 1); else m_ovf = 1;
      return 0;
    end
`ifdef PUZZLE_UNDO_EN
    if (m_route.size() == 0) return 1;
    if (!model_try((m_route[$] - 1) ^ 1)) return 1;
    void'(m_route.pop_back());
    return 0;
`else
    return 1;
`endif
  endfunction

  function automatic bit model_solved();
    for (int k = 0; k < NC - 1; k++) if (m_board[k] != k + 1) return 0;
    return m_board[NC-1] == 0;
  endfunction

  task automatic rd(input int a, output logic [7:0] v);
    bus.host_addr = AW'(a); #1; v = bus.host_dout;
  endtask

  task automatic wr(input int a, input int v);
    @(negedge clk); bus.host_we = 1; bus.host_addr = AW'(a); bus.host_din = W'(v);
    @(posedge clk); #1; bus.host_we = 0;
  endtask

  // issues one request; pat[i] = move_done sampled after the (i+1)th edge from accept
  task automatic do_req(input bit undo, input int dir, output logic [3:0] pat, output logic err);
    @(negedge clk);
    bus.move_valid = !undo; bus.undo_valid = undo; bus.move_dir = 2'(dir);
    @(posedge clk); #1; pat[0] = bus.move_done; bus.move_valid = 0; bus.undo_valid = 0;
    @(posedge clk); #1; pat[1] = bus.move_done;
    @(posedge clk); #1; pat[2] = bus.move_done; err = bus.move_err;
    @(posedge clk); #1; pat[3] = bus.move_done;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1; @(negedge clk); rst = 0; model_reset();
  endtask

  task automatic pulse_clr();
    @(negedge clk); route_clr = 1; @(posedge clk); #1; route_clr = 0;
    m_route.delete(); m_ovf = 0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; model_reset();
    for (int k = 0; k < NC; k++) begin
      rd(k, v); n_tests++;
      if (v !== 8'(init_b[k])) begin n_fail++; $display("FAIL reset_cell%0d: got %0d exp %0d", k, v, init_b[k]); end
    end
    n_tests++; if (blank_pos !== 4'd8) begin n_fail++; $display("FAIL reset_blank: got %0d exp 8", blank_pos); end
    n_tests++; if (route_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", route_cnt); end
    n_tests++; if (solved !== 1'b0) begin n_fail++; $display("FAIL reset_solved: got %0b exp 0", solved); end
    n_tests++; if (bus.move_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b exp 1", bus.move_ready); end
    n_tests++; if (bus.move_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b exp 0", bus.move_done); end
  endtask

  task automatic test_illegal();
    logic [3:0] pat; logic err; logic [7:0] v; bit e;
    e = model_req(0, 1);
    do_req(0, 1, pat, err);
    n_tests++; if (pat !== 4'b0100) begin n_fail++; $display("FAIL illegal_latency: got %b exp 0100", pat); end
    n_tests++; if (err !== e) begin n_fail++; $display("FAIL illegal_err: got %0b exp %0b", err, e); end
    for (int k = 0; k < NC; k++) begin
      rd(k, v); n_tests++;
      if (v !== 8'(m_board[k])) begin n_fail++; $display("FAIL illegal_cell%0d: got %0d exp %0d", k, v, m_board[k]); end
    end
    n_tests++; if (route_cnt !== 3'd0) begin n_fail++; $display("FAIL illegal_cnt: got %0d exp 0", route_cnt); end
  endtask

  task automatic test_legal();
    logic [3:0] pat; logic err; logic [7:0] v;
    void'(model_req(0, 2));
    do_req(0, 2, pat, err);
    n_tests++; if (pat !== 4'b0100) begin n_fail++; $display("FAIL legal_latency: got %b exp 0100", pat); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL legal_err: got %0b exp 0", err); end
    rd(7, v); n_tests++; if (v !== 8'd0) begin n_fail++; $display("FAIL legal_cell7: got %0d exp 0", v); end
    rd(8, v); n_tests++; if (v !== 8'd8) begin n_fail++; $display("FAIL legal_cell8: got %0d exp 8", v); end
    rd(16, v); n_tests++; if (v !== 8'd3) begin n_fail++; $display("FAIL legal_route0: got %0d exp 3", v); end
    n_tests++; if (blank_pos !== 4'd7) begin n_fail++; $display("FAIL legal_blank: got %0d exp 7", blank_pos); end
    n_tests++; if (route_cnt !== 3'd1) begin n_fail++; $display("FAIL legal_cnt: got %0d exp 1", route_cnt); end
  endtask

  task automatic test_overflow_clr();
    int dirs[5] = '{2, 0, 3, 1, 2};
    logic [3:0] pat; logic err; logic [7:0] v; bit e;
    pulse_reset();
    foreach (dirs[i]) begin
      e = model_req(0, dirs[i]);
      do_req(0, dirs[i], pat, err);
      n_tests++; if (err !== e) begin n_fail++; $display("FAIL ovf_err%0d: got %0b exp %0b", i, err, e); end
    end
    n_tests++; if (route_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt: got %0d exp 4", route_cnt); end
    n_tests++; if (route_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b exp 1", route_ovf); end
    n_tests++; if (blank_pos !== 4'(m_blank)) begin n_fail++; $display("FAIL ovf_blank: got %0d exp %0d", blank_pos, m_blank); end
    for (int k = 0; k < NC; k++) begin
      rd(k, v); n_tests++;
      if (v !== 8'(m_board[k])) begin n_fail++; $display("FAIL ovf_cell%0d: got %0d exp %0d", k, v, m_board[k]); end
    end
    pulse_clr();
    n_tests++; if (route_cnt !== 3'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d exp 0", route_cnt); end
    n_tests++; if (route_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %0b exp 0", route_ovf); end
    for (int a = RB; a < RB + R; a++) begin
      rd(a, v); n_tests++;
      if (v !== 8'd0) begin n_fail++; $display("FAIL clr_route%0d: got %0d exp 0", a, v); end
    end
    wr(17, 5); wr(100, 9);
    rd(17, v);  n_tests++; if (v !== 8'd0) begin n_fail++; $display("FAIL route_wr_drop: got %0d exp 0", v); end
    rd(100, v); n_tests++; if (v !== 8'd0) begin n_fail++; $display("FAIL unmapped_rd: got %0d exp 0", v); end
  endtask

  task automatic test_busy_write();
    logic [7:0] v;
    @(negedge clk); bus.move_valid = 1; bus.move_dir = 2'd0;
    @(posedge clk); #1; bus.move_valid = 0;
    bus.host_we = 1; bus.host_addr = 8'd0; bus.host_din = 8'd99;
    @(posedge clk); #1; bus.host_we = 0;
    repeat (2) @(posedge clk); #1;
    void'(model_req(0, 0));
    rd(0, v); n_tests++; if (v !== 8'(m_board[0])) begin n_fail++; $display("FAIL busy_write: got %0d exp %0d", v, m_board[0]); end
    n_tests++; if (blank_pos !== 4'(m_blank)) begin n_fail++; $display("FAIL busy_blank: got %0d exp %0d", blank_pos, m_blank); end
  endtask

  task automatic test_solved_undo();
    logic [3:0] pat; logic err; bit e;
    pulse_clr();
    for (int k = 0; k < NC; k++) begin
      int val = (k == NC - 1) ? 0 : k + 1;
      wr(k, val); m_board[k] = val; if (val == 0) m_blank = k;
    end
    @(posedge clk); #1;
    n_tests++; if (solved !== 1'b1) begin n_fail++; $display("FAIL solved_load: got %0b exp 1", solved); end
    n_tests++; if (blank_pos !== 4'd8) begin n_fail++; $display("FAIL solved_blank: got %0d exp 8", blank_pos); end
    e = model_req(0, 0);
    do_req(0, 0, pat, err);
    n_tests++; if (err !== e) begin n_fail++; $display("FAIL up_err: got %0b exp %0b", err, e); end
    n_tests++; if (solved !== 1'b0) begin n_fail++; $display("FAIL up_solved: got %0b exp 0", solved); end
    e = model_req(1, 0);
    do_req(1, 0, pat, err);
    n_tests++; if (pat !== 4'b0100) begin n_fail++; $display("FAIL undo_latency: got %b exp 0100", pat); end
    n_tests++; if (err !== e) begin n_fail++; $display("FAIL undo1_err: got %0b exp %0b", err, e); end
    n_tests++; if (solved !== model_solved()) begin n_fail++; $display("FAIL undo_solved: got %0b exp %0b", solved, model_solved()); end
    n_tests++; if (route_cnt !== 3'(m_route.size())) begin n_fail++; $display("FAIL undo_cnt: got %0d exp %0d", route_cnt, m_route.size()); end
    n_tests++; if (blank_pos !== 4'(m_blank)) begin n_fail++; $display("FAIL undo_blank: got %0d exp %0d", blank_pos, m_blank); end
`ifdef PUZZLE_UNDO_EN
    e = model_req(1, 0);
    do_req(1, 0, pat, err);
    n_tests++; if (err !== e || err !== 1'b1) begin n_fail++; $display("FAIL undo2_err: got %0b exp 1", err); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] v; bit saw = 0;
    @(negedge clk); bus.move_valid = 1; bus.move_dir = 2'd2;
    @(posedge clk); #1; bus.move_valid = 0;
    #2; rst = 1; #1;
    for (int k = 0; k < NC; k++) begin
      rd(k, v); n_tests++;
      if (v !== 8'(init_b[k])) begin n_fail++; $display("FAIL midrst_cell%0d: got %0d exp %0d", k, v, init_b[k]); end
    end
    n_tests++; if (blank_pos !== 4'd8) begin n_fail++; $display("FAIL midrst_blank: got %0d exp 8", blank_pos); end
    @(negedge clk); rst = 0; model_reset();
    repeat (4) begin @(posedge clk); #1; if (bus.move_done) saw = 1; end
    n_tests++; if (saw) begin n_fail++; $display("FAIL midrst_done: got 1 exp 0"); end
    n_tests++; if (bus.move_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %0b exp 1", bus.move_ready); end
  endtask

  task automatic test_random();
    logic [3:0] pat; logic err; logic [7:0] v; bit e, undo; int dir;
    pulse_reset();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) pulse_clr();
      undo = ($urandom_range(0, 3) == 0);
      dir  = $urandom_range(0, 3);
      e = model_req(undo, dir);
      do_req(undo, dir, pat, err);
      n_tests++; if (pat !== 4'b0100) begin n_fail++; $display("FAIL rnd%0d_latency: got %b exp 0100", it, pat); end
      n_tests++; if (err !== e) begin n_fail++; $display("FAIL rnd%0d_err: got %0b exp %0b", it, err, e); end
      n_tests++; if (blank_pos !== 4'(m_blank)) begin n_fail++; $display("FAIL rnd%0d_blank: got %0d exp %0d", it, blank_pos, m_blank); end
      n_tests++; if (route_cnt !== 3'(m_route.size())) begin n_fail++; $display("FAIL rnd%0d_cnt: got %0d exp %0d", it, route_cnt, m_route.size()); end
      n_tests++; if (route_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd%0d_ovf: got %0b exp %0b", it, route_ovf, m_ovf); end
      for (int k = 0; k < NC; k++) begin
        rd(k, v); n_tests++;
        if (v !== 8'(m_board[k])) begin n_fail++; $display("FAIL rnd%0d_cell%0d: got %0d exp %0d", it, k, v, m_board[k]); end
      end
      for (int a = 0; a < R; a++) begin
        int exp_e = (a < m_route.size()) ? m_route[a] : 0;
        rd(RB + a, v); n_tests++;
        if (v !== 8'(exp_e)) begin n_fail++; $display("FAIL rnd%0d_route%0d: got %0d exp %0d", it, a, v, exp_e); end
      end
    end
  endtask

  initial begin
    bus.host_addr = '0; bus.host_we = 0; bus.host_din = '0;
    bus.move_valid = 0; bus.move_dir = '0; bus.undo_valid = 0;
    test_reset();
    test_illegal();
    test_legal();
    test_overflow_clr();
    test_busy_write();
    test_solved_undo();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
